// File: rtl/seg_scan_driver.sv
// Four-digit time-multiplexed seven-segment driver. One digit is selected
// per scan tick. The digits are captured once per frame, so all four digits
// of a frame come from the same sample. Per-digit blink and leading-zero
// blanking are applied here, so upstream logic only has to supply masks.
module seg_scan_driver #(
  parameter int BLINK_DIV  = 250,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic [15:0] digits,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lead,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int             CW      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(BLINK_DIV - 1);

  logic [1:0]    scan_idx, idx_nxt;
  logic [CW-1:0] blink_cnt, cnt_nxt;
  logic          blink_phase, phase_nxt;
  logic [15:0]   shadow, shadow_nxt;
  logic          cnt_wrap, lz, blank;
  logic [3:0]    digit_sel;
  logic [3:0]    an_act;
  logic [6:0]    seg_act;
  logic          dp_act;

  // BCD to segments, active-high, bit order g..a; 10..15 show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;
    endcase
  endfunction

  // Next-tick state. The pins are computed from the post-tick index, shadow,
  // and blink phase, so a freshly captured frame shows on its first digit.
  always_comb begin
    idx_nxt    = scan_idx + 2'd1;
    shadow_nxt = (scan_idx == 2'd3) ? digits : shadow;
    cnt_wrap   = (blink_cnt == CNT_MAX);
    cnt_nxt    = cnt_wrap ? '0 : blink_cnt + CW'(1);
    phase_nxt  = blink_phase ^ cnt_wrap;
    digit_sel  = shadow_nxt[{idx_nxt, 2'b00} +: 4];

    // Only the two leftmost digits are candidates for zero suppression;
    // digit 2 goes dark only when digit 3 is also zero.
    case (idx_nxt)
      2'd3:    lz = blank_lead && (shadow_nxt[15:12] == 4'h0);
      2'd2:    lz = blank_lead && (shadow_nxt[15:8] == 8'h00);
      default: lz = 1'b0;
    endcase

    blank   = lz | (phase_nxt & blink_mask[idx_nxt]);
    an_act  = blank ? 4'b0000 : (4'b0001 << idx_nxt);
    seg_act = blank ? 7'b0000000 : decode(digit_sel);
    dp_act  = dp_mask[idx_nxt] & ~blank;
  end

  // Scan, capture, blink, and output registers; all advance only on tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_idx    <= 2'd0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      shadow      <= 16'h0000;
      an          <= {4{ACTIVE_LOW}};
      seg         <= {7{ACTIVE_LOW}};
      dp          <= ACTIVE_LOW;
    end else if (tick) begin
      scan_idx    <= idx_nxt;
      blink_cnt   <= cnt_nxt;
      blink_phase <= phase_nxt;
      shadow      <= shadow_nxt;
      an          <= an_act  ^ {4{ACTIVE_LOW}};
      seg         <= seg_act ^ {7{ACTIVE_LOW}};
      dp          <= dp_act  ^ ACTIVE_LOW;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver. An active-low and an active-high
// instance share the same stimulus. Both use a short blink period.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [15:0] digits;
  logic [3:0]  blink_mask, dp_mask;
  logic        blank_lead;
  logic [3:0]  an_l, an_h;
  logic [6:0]  seg_l, seg_h;
  logic        dp_l, dp_h;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seg_scan_driver #(.BLINK_DIV(4), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .digits(digits),
    .blink_mask(blink_mask), .dp_mask(dp_mask), .blank_lead(blank_lead),
    .an(an_l), .seg(seg_l), .dp(dp_l)
  );

  seg_scan_driver #(.BLINK_DIV(4), .ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .tick(tick), .digits(digits),
    .blink_mask(blink_mask), .dp_mask(dp_mask), .blank_lead(blank_lead),
    .an(an_h), .seg(seg_h), .dp(dp_h)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Hold tick for n consecutive cycles, then sample on the falling edge.
  task automatic ticks(input int n);
    @(negedge clk);
    tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
  endtask

  // Active-low pin check for one selected digit.
  task automatic pins(input string tag, input logic [3:0] an_e,
                      input logic [6:0] seg_e, input logic dp_e);
    check({tag, ".an"},  {12'h0, an_l},  {12'h0, an_e});
    check({tag, ".seg"}, {9'h0, seg_l},  {9'h0, seg_e});
    check({tag, ".dp"},  {15'h0, dp_l},  {15'h0, dp_e});
  endtask

  initial begin
    rst_n = 1'b0; tick = 1'b0; digits = 16'h1234;
    blink_mask = 4'b0000; dp_mask = 4'b0000; blank_lead = 1'b0;

    // Reset holds outputs inactive even with ticks running.
    repeat (2) @(negedge clk);
    tick = 1'b1;
    repeat (3) @(negedge clk);
    tick = 1'b0;
    pins("rst", 4'b1111, 7'h7F, 1'b1);
    check("rst.hi.an",  {12'h0, an_h},  16'h0000);
    check("rst.hi.seg", {9'h0, seg_h},  16'h0000);
    check("rst.hi.dp",  {15'h0, dp_h},  16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // First tick: index 1, shadow still zero.
    ticks(1);
    pins("t1", 4'b1101, 7'h40, 1'b1);
    repeat (5) @(negedge clk);
    check("hold.an", {12'h0, an_l}, 16'h000D);
    ticks(2);
    check("t3.an", {12'h0, an_l}, 16'h0007);
    // Wrap captures 1234, and digit 0 shows "4".
    ticks(1);
    pins("cap4", 4'b1110, 7'h19, 1'b1);
    check("cap4.hi.an",  {12'h0, an_h}, 16'h0001);
    check("cap4.hi.seg", {9'h0, seg_h}, 16'h0066);
    ticks(1);
    pins("cap3", 4'b1101, 7'h30, 1'b1);
    digits = 16'h5678;          // mid-frame change must not tear
    ticks(1);
    pins("cap2", 4'b1011, 7'h24, 1'b1);
    ticks(1);
    pins("cap1", 4'b0111, 7'h79, 1'b1);
    ticks(1);
    pins("cap8", 4'b1110, 7'h00, 1'b1);

    // Leading-zero blanking.
    digits = 16'h0005; blank_lead = 1'b1;
    ticks(3);
    ticks(1);
    pins("lz5", 4'b1110, 7'h12, 1'b1);
    digits = 16'h0105;
    ticks(1);
    pins("lz0", 4'b1101, 7'h40, 1'b1);
    ticks(1);
    pins("lz.d2", 4'b1111, 7'h7F, 1'b1);
    ticks(1);
    pins("lz.d3", 4'b1111, 7'h7F, 1'b1);
    ticks(3);
    pins("lz.d2b", 4'b1011, 7'h79, 1'b1);
    ticks(1);
    pins("lz.d3b", 4'b1111, 7'h7F, 1'b1);

    // Decode of values 10..15 and decimal point.
    digits = 16'hF9A0; dp_mask = 4'b0100; blank_lead = 1'b0;
    ticks(1);
    pins("dec0", 4'b1110, 7'h40, 1'b1);
    ticks(1);
    pins("decA", 4'b1101, 7'h3F, 1'b1);
    ticks(1);
    pins("dec9", 4'b1011, 7'h10, 1'b0);
    check("dec9.hi.dp", {15'h0, dp_h}, 16'h0001);
    ticks(1);
    pins("decF", 4'b0111, 7'h3F, 1'b1);

    // Blink: 23 ticks so far. The phase after tick k is (k/4)%2, so
    // digits 0 and 1 go dark for ticks 28..31.
    dp_mask = 4'b0000; blink_mask = 4'b0011;
    for (int k = 24; k < 36; k++) begin
      logic [3:0] an_e;
      ticks(1);
      an_e = (((k / 4) % 2 == 1) && (k % 4 < 2)) ? 4'b1111 : ~(4'b0001 << (k % 4));
      check($sformatf("blink%0d", k), {12'h0, an_l}, {12'h0, an_e});
    end

    // Tick held high for two cycles counts twice: 3 -> 1.
    blink_mask = 4'b0000;
    ticks(2);
    pins("hold2", 4'b1101, 7'h3F, 1'b1);

    // Mid-frame asynchronous reset, then resume from index 0 with an empty shadow.
    #2 rst_n = 1'b0;
    #1 check("mrst.an", {12'h0, an_l}, 16'h000F);
    check("mrst.seg", {9'h0, seg_l}, 16'h007F);
    @(negedge clk);
    rst_n = 1'b1;
    ticks(1);
    pins("mrst.t1", 4'b1101, 7'h40, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
